pipelined_simd_controller: RTL

Pipelined control unit for the SIMD AES datapath. It decodes one 32-bit instruction per cycle into the control word, registers that word through the EX, MEM and WB stages, and sequences vector instructions over several lane-group beats. It handles stall and flush, and it reports illegal instructions. It sits between the instruction register and the datapath and replaces the purely combinational controller.

---
 rtl/pipelined_simd_controller.sv | 283 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/pipelined_simd_controller.sv
// pipelined_simd_controller
//
// Pipelined control unit for the SIMD AES datapath. Decodes one instruction
// per cycle into a control word, carries it through the EX, MEM and WB
// pipeline registers, and sequences vector instructions over LANES/PAR
// lane-group beats. Handles stall and flush, and reports illegal instructions.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   Instruction     instruction in the decode stage
//   stall           hazard stall: bubble into EX, Instruction not consumed
//   flush           taken branch: kill the instructions in EX and MEM
//   busy            vector sequence in progress, upstream holds Instruction
//   illegal         one-cycle pulse, aligned with the EX bubble it caused
//   ALUControl, ALUScr, VecOp, LaneGroup   EX stage controls
//   MemWrite, Branch                       MEM stage controls
//   RegWrite, MemToReg                     WB stage controls
//
// Vector sequencer states
//   state  | meaning
//   S_IDLE | decoding a new instruction every cycle
//   S_SEQ  | reissuing the latched vector word, one lane group per beat

module pipelined_simd_controller #(
  parameter int BITS  = 32,
  parameter int LANES = 4,
  parameter int PAR   = 2,
  parameter int GW    = ((LANES / PAR) > 1) ? $clog2(LANES / PAR) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [BITS-1:0] Instruction,
  input  logic            stall,
  input  logic            flush,
  output logic            busy,
  output logic            illegal,
  output logic [2:0]      ALUControl,
  output logic            ALUScr,
  output logic            VecOp,
  output logic [GW-1:0]   LaneGroup,
  output logic            MemWrite,
  output logic            Branch,
  output logic            RegWrite,
  output logic            MemToReg
);

  localparam int BEATS = LANES / PAR;
  localparam bit MULTI = (BEATS > 1);
  localparam logic [GW-1:0] LAST_GROUP = GW'(BEATS - 1);

  localparam logic [4:0] OP_R      = 5'b01100;
  localparam logic [4:0] OP_I      = 5'b00100;
  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_VEC    = 5'b00010;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLL = 3'b101;

  typedef struct packed {
    logic [2:0] alu_ctrl;
    logic       alu_src;
    logic       vec_op;
    logic       mem_write;
    logic       branch;
    logic       reg_write;
    logic       mem_to_reg;
  } ctrl_t;

  typedef struct packed {
    logic mem_write;
    logic branch;
    logic reg_write;
    logic mem_to_reg;
  } mem_ctrl_t;

  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
  } wb_ctrl_t;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SEQ  = 1'b1
  } state_t;

  logic [4:0] opcode;
  logic [2:0] funct3;
  logic       funct7b5;

  assign opcode   = Instruction[6:2];
  assign funct3   = Instruction[14:12];
  assign funct7b5 = Instruction[30];

  // Fields outside opcode/funct3/funct7b5 carry register numbers and
  // immediates that this unit never looks at.
  logic unused_instr_bits;
  assign unused_instr_bits = ^{Instruction[BITS-1:31], Instruction[29:15],
                               Instruction[11:7], Instruction[1:0]};

  ctrl_t     dec;
  logic      dec_bad;
  logic      uses_funct;
  logic      sub_ok;

  state_t    state, state_next;
  logic [GW-1:0] beat_cnt, cnt_next;
  logic      latch_vec;
  ctrl_t     vec_word;

  ctrl_t     ex_next;
  logic [GW-1:0] lg_next;
  logic      ill_next;

  ctrl_t     id_ex;
  logic [GW-1:0] ex_lg;
  logic      illegal_q;
  mem_ctrl_t ex_mem;
  wb_ctrl_t  mem_wb;

  // Instruction decode. An illegal encoding collapses to a bubble here so
  // nothing downstream needs to know about it except the illegal pulse.
  always_comb begin
    dec        = '0;
    dec_bad    = 1'b0;
    uses_funct = 1'b0;
    sub_ok     = 1'b0;
    case (opcode)
      OP_R: begin
        dec.reg_write = 1'b1;
        uses_funct    = 1'b1;
        sub_ok        = 1'b1;
      end
      OP_I: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        uses_funct    = 1'b1;
      end
      OP_LOAD: begin
        dec.reg_write  = 1'b1;
        dec.mem_to_reg = 1'b1;
        dec.alu_src    = 1'b1;
        dec.alu_ctrl   = ALU_ADD;
      end
      OP_STORE: begin
        dec.mem_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.alu_ctrl  = ALU_ADD;
      end
      OP_BRANCH: begin
        dec.branch   = 1'b1;
        dec.alu_ctrl = ALU_SUB;
      end
      OP_VEC: begin
        dec.vec_op    = 1'b1;
        dec.reg_write = 1'b1;
        uses_funct    = 1'b1;
        sub_ok        = 1'b1;
      end
      default: dec_bad = 1'b1;
    endcase
    if (uses_funct) begin
      case (funct3)
        3'b000:  dec.alu_ctrl = (sub_ok && funct7b5) ? ALU_SUB : ALU_ADD;
        3'b111:  dec.alu_ctrl = ALU_AND;
        3'b110:  dec.alu_ctrl = ALU_OR;
        3'b100:  dec.alu_ctrl = ALU_XOR;
        3'b001:  dec.alu_ctrl = ALU_SLL;
        default: dec_bad = 1'b1;
      endcase
    end
    if (dec_bad) dec = '0;
  end

  // Sequencer state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      beat_cnt <= '0;
      vec_word <= '0;
    end else begin
      state    <= state_next;
      beat_cnt <= cnt_next;
      if (latch_vec) vec_word <= dec;
    end
  end

  // Sequencer next state
  always_comb begin
    state_next = state;
    cnt_next   = beat_cnt;
    latch_vec  = 1'b0;
    case (state)
      S_IDLE: begin
        if (!flush && !stall && dec.vec_op) begin
          latch_vec = 1'b1;
          if (MULTI) begin
            state_next = S_SEQ;
            cnt_next   = GW'(1);
          end
        end
      end
      S_SEQ: begin
        if (flush) begin
          state_next = S_IDLE;
          cnt_next   = '0;
        end else if (!stall) begin
          // The final group issues on the same edge that leaves SEQ, so
          // busy falls together with the last beat.
          if (beat_cnt == LAST_GROUP) begin
            state_next = S_IDLE;
            cnt_next   = '0;
          end else begin
            cnt_next = beat_cnt + GW'(1);
          end
        end
      end
      default: begin
        state_next = S_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Word loaded into ID/EX: flush and stall both force a bubble; in SEQ the
  // latched vector word is replayed and Instruction is ignored.
  always_comb begin
    ex_next  = '0;
    lg_next  = '0;
    ill_next = 1'b0;
    if (!flush && !stall) begin
      if (state == S_SEQ) begin
        ex_next = vec_word;
        lg_next = beat_cnt;
      end else begin
        ex_next  = dec;
        ill_next = dec_bad;
      end
    end
  end

  // Pipeline registers. EX/MEM and MEM/WB always advance; flush only
  // bubbles ID/EX and EX/MEM so the instruction already in MEM retires.
  always_ff @(posedge clk) begin
    if (rst) begin
      id_ex     <= '0;
      ex_lg     <= '0;
      illegal_q <= 1'b0;
      ex_mem    <= '0;
      mem_wb    <= '0;
    end else begin
      id_ex     <= ex_next;
      ex_lg     <= lg_next;
      illegal_q <= ill_next;
      if (flush) begin
        ex_mem <= '0;
      end else begin
        ex_mem <= '{mem_write:  id_ex.mem_write,
                    branch:     id_ex.branch,
                    reg_write:  id_ex.reg_write,
                    mem_to_reg: id_ex.mem_to_reg};
      end
      mem_wb <= '{reg_write: ex_mem.reg_write, mem_to_reg: ex_mem.mem_to_reg};
    end
  end

  assign busy       = (state == S_SEQ);
  assign illegal    = illegal_q;
  assign ALUControl = id_ex.alu_ctrl;
  assign ALUScr     = id_ex.alu_src;
  assign VecOp      = id_ex.vec_op;
  assign LaneGroup  = ex_lg;
  assign MemWrite   = ex_mem.mem_write;
  assign Branch     = ex_mem.branch;
  assign RegWrite   = mem_wb.reg_write;
  assign MemToReg   = mem_wb.mem_to_reg;

endmodule
